// File: rtl/order_book_mem_ctrl.sv
// ----------------------------------------------------------------------------
// order_book_mem_ctrl
//
// Command-side initiator for the order-book entry memory. The memory has a
// one-cycle registered read and no reset of its own, so after every reset this
// block sweeps zeros through every slot before accepting commands. It then
// executes one order command at a time as read / evaluate / optional write,
// and returns a status plus an entry word.
//
// Entry layout (DATA_W = 129):
//   [128] valid  [127] side  [126:95] price  [94:63] qty  [62:0] order_id
//
// Ports
//   clk, reset               single clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only in IDLE after init)
//   cmd_op                   0 ADD, 1 CANCEL, 2 REDUCE, 3 READ
//   cmd_slot, cmd_side, cmd_price, cmd_qty, cmd_id   command fields
//   rsp_valid / rsp_ready    response handshake; response held until ready
//   rsp_status               0 OK, 1 EMPTY, 2 OCCUPIED, 3 ID_MISMATCH
//   rsp_entry                entry word returned for the command
//   mem_wr_valid, mem_rd_valid, mem_address, mem_wdata   memory request port
//   mem_rdata                memory read data, valid the cycle after a read
//   init_done                clear sweep finished (sticky until reset)
//
// Every output is registered, and its value always matches the current state.
// Accept -> rsp_valid takes 3 cycles (RD, EVAL, RESP) when nothing is written,
// and 4 cycles (RD, EVAL, WR, RESP) when the slot is written.
// ----------------------------------------------------------------------------
module order_book_mem_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 129
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_slot,
    input  logic              cmd_side,
    input  logic [31:0]       cmd_price,
    input  logic [31:0]       cmd_qty,
    input  logic [62:0]       cmd_id,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_entry,
    output logic              mem_wr_valid,
    output logic              mem_rd_valid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              init_done
);

    localparam int VALID_BIT = 128;
    localparam int QTY_LSB   = 63;
    localparam int ID_W      = 63;

    // The sweep pointer is one bit wider so it can count past the last slot.
    localparam logic [ADDR_W:0] SWEEP_END = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] OP_ADD    = 2'd0;
    localparam logic [1:0] OP_CANCEL = 2'd1;
    localparam logic [1:0] OP_REDUCE = 2'd2;

    localparam logic [1:0] ST_OK          = 2'd0;
    localparam logic [1:0] ST_EMPTY       = 2'd1;
    localparam logic [1:0] ST_OCCUPIED    = 2'd2;
    localparam logic [1:0] ST_ID_MISMATCH = 2'd3;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_RD   = 3'd2,
        S_EVAL = 3'd3,
        S_WR   = 3'd4,
        S_RESP = 3'd5
    } state_t;

    // Remaining quantity after a REDUCE; clamps at zero rather than wrapping.
    function automatic logic [31:0] sat_sub_qty(input logic [31:0] have,
                                                input logic [31:0] take);
        if (take >= have) begin
            return 32'd0;
        end
        return have - take;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              init_done_q, init_done_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [DATA_W-1:0] rsp_entry_q, rsp_entry_d;
    logic              mem_wr_valid_q, mem_wr_valid_d;
    logic              mem_rd_valid_q, mem_rd_valid_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Captured command (datapath only, no reset needed).
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] slot_q, slot_d;
    logic              side_q, side_d;
    logic [31:0]       price_q, price_d;
    logic [31:0]       qty_q, qty_d;
    logic [ID_W-1:0]   id_q, id_d;

    // Decision made in EVAL from the old entry read back from memory.
    logic              old_valid;
    logic [31:0]       old_qty;
    logic [ID_W-1:0]   old_id;
    logic [31:0]       left_qty;
    logic              ev_write;
    logic [1:0]        ev_status;
    logic [DATA_W-1:0] ev_word;
    logic [DATA_W-1:0] ev_entry;

    always_comb begin
        old_valid = mem_rdata[VALID_BIT];
        old_qty   = mem_rdata[QTY_LSB +: 32];
        old_id    = mem_rdata[ID_W-1:0];
        left_qty  = sat_sub_qty(old_qty, qty_q);
        ev_write  = 1'b0;
        ev_status = ST_OK;
        ev_word   = '0;
        ev_entry  = mem_rdata;
        case (op_q)
            OP_ADD: begin
                if (old_valid) begin
                    ev_status = ST_OCCUPIED;
                end else begin
                    ev_write = 1'b1;
                    ev_word  = {1'b1, side_q, price_q, qty_q, id_q};
                    ev_entry = ev_word;
                end
            end
            OP_CANCEL: begin
                if (!old_valid) begin
                    ev_status = ST_EMPTY;
                end else if (old_id != id_q) begin
                    ev_status = ST_ID_MISMATCH;
                end else begin
                    // Cleared slot; the response still reports what was removed.
                    ev_write = 1'b1;
                end
            end
            OP_REDUCE: begin
                if (!old_valid) begin
                    ev_status = ST_EMPTY;
                end else if (old_id != id_q) begin
                    ev_status = ST_ID_MISMATCH;
                end else begin
                    ev_write = 1'b1;
                    // A fully consumed order frees the slot entirely.
                    if (left_qty != 32'd0) begin
                        ev_word = {mem_rdata[DATA_W-1:QTY_LSB+32], left_qty,
                                   mem_rdata[QTY_LSB-1:0]};
                    end
                    ev_entry = ev_word;
                end
            end
            default: begin
                ev_status = old_valid ? ST_OK : ST_EMPTY;
            end
        endcase
    end

    // Next-state and next-output logic. Output registers are loaded with the
    // values belonging to the state being entered.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        init_done_d    = init_done_q;
        cmd_ready_d    = 1'b0;
        rsp_valid_d    = 1'b0;
        rsp_status_d   = rsp_status_q;
        rsp_entry_d    = rsp_entry_q;
        mem_wr_valid_d = 1'b0;
        mem_rd_valid_d = 1'b0;
        mem_address_d  = '0;
        mem_wdata_d    = '0;
        op_d           = op_q;
        slot_d         = slot_q;
        side_d         = side_q;
        price_d        = price_q;
        qty_d          = qty_q;
        id_d           = id_q;

        unique case (state_q)
            S_INIT: begin
                if (ptr_q != SWEEP_END) begin
                    mem_wr_valid_d = 1'b1;
                    mem_address_d  = ptr_q[ADDR_W-1:0];
                    ptr_d          = ptr_q + 1'b1;
                end else begin
                    // Last clear write is on the bus this cycle.
                    init_done_d = 1'b1;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    op_d           = cmd_op;
                    slot_d         = cmd_slot;
                    side_d         = cmd_side;
                    price_d        = cmd_price;
                    qty_d          = cmd_qty;
                    id_d           = cmd_id;
                    cmd_ready_d    = 1'b0;
                    mem_rd_valid_d = 1'b1;
                    mem_address_d  = cmd_slot;
                    state_d        = S_RD;
                end
            end
            S_RD: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                rsp_status_d = ev_status;
                rsp_entry_d  = ev_entry;
                if (ev_write) begin
                    mem_wr_valid_d = 1'b1;
                    mem_address_d  = slot_q;
                    mem_wdata_d    = ev_word;
                    state_d        = S_WR;
                end else begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_INIT;
            ptr_q          <= '0;
            init_done_q    <= 1'b0;
            cmd_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_status_q   <= '0;
            rsp_entry_q    <= '0;
            mem_wr_valid_q <= 1'b0;
            mem_rd_valid_q <= 1'b0;
            mem_address_q  <= '0;
            mem_wdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            init_done_q    <= init_done_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_status_q   <= rsp_status_d;
            rsp_entry_q    <= rsp_entry_d;
            mem_wr_valid_q <= mem_wr_valid_d;
            mem_rd_valid_q <= mem_rd_valid_d;
            mem_address_q  <= mem_address_d;
            mem_wdata_q    <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q    <= op_d;
        slot_q  <= slot_d;
        side_q  <= side_d;
        price_q <= price_d;
        qty_q   <= qty_d;
        id_q    <= id_d;
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_status   = rsp_status_q;
    assign rsp_entry    = rsp_entry_q;
    assign mem_wr_valid = mem_wr_valid_q;
    assign mem_rd_valid = mem_rd_valid_q;
    assign mem_address  = mem_address_q;
    assign mem_wdata    = mem_wdata_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_order_book_mem_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for order_book_mem_ctrl: behavioural entry memory, directed
// command vectors with expected responses queued at issue time, and a monitor
// that pops and compares whenever a response is handed over.
// ----------------------------------------------------------------------------
module tb_order_book_mem_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 129;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [1:0] OP_ADD = 2'd0, OP_CANCEL = 2'd1, OP_REDUCE = 2'd2, OP_READ = 2'd3;
    localparam logic [1:0] ST_OK = 2'd0, ST_EMPTY = 2'd1, ST_OCCUPIED = 2'd2, ST_ID_MISMATCH = 2'd3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [ADDR_W-1:0] cmd_slot = '0;
    logic              cmd_side = 1'b0;
    logic [31:0]       cmd_price = '0;
    logic [31:0]       cmd_qty = '0;
    logic [62:0]       cmd_id = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_status;
    logic [DATA_W-1:0] rsp_entry;
    logic              mem_wr_valid;
    logic              mem_rd_valid;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              init_done;

    order_book_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_slot(cmd_slot), .cmd_side(cmd_side), .cmd_price(cmd_price),
        .cmd_qty(cmd_qty), .cmd_id(cmd_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_entry(rsp_entry),
        .mem_wr_valid(mem_wr_valid), .mem_rd_valid(mem_rd_valid),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Behavioural memory: registered read, write has priority; preloaded with
    // all-ones garbage so the clear sweep is observable.
    logic [DATA_W-1:0] mem [DEPTH];
    bit                preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= {DATA_W{1'b1}};
            preloaded <= 1'b1;
        end else if (mem_wr_valid) begin
            mem[mem_address] <= mem_wdata;
        end else if (mem_rd_valid) begin
            mem_rdata <= mem[mem_address];
        end
    end

    typedef struct packed {
        logic [1:0]        st;
        logic [DATA_W-1:0] entry;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   wr_cnt = 0;
    int   overlap = 0;

    function automatic logic [DATA_W-1:0] mk(input logic side, input logic [31:0] price,
                                             input logic [31:0] qty, input logic [62:0] id);
        return {1'b1, side, price, qty, id};
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ent(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_wr_valid) wr_cnt++;
            if (mem_wr_valid && mem_rd_valid) overlap++;
            if (!reset && rsp_valid && rsp_ready) begin
                check_int("rsp_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_int("rsp_status", int'(rsp_status), int'(e.st));
                    check_ent("rsp_entry", rsp_entry, e.entry);
                end
            end
        end
    endtask

    // Checks the full clear sweep that follows a reset.
    task automatic init_seq(input string tag);
        int bad;
        bit seen;
        bad  = 0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (mem_wr_valid) seen = 1'b1;
        end
        check_int({tag, "_sweep_start"}, int'(seen), 1);
        if (seen) begin
            for (int a = 0; a < DEPTH; a++) begin
                if (a != 0) @(negedge clk);
                if (!mem_wr_valid || mem_rd_valid || mem_address != a[ADDR_W-1:0] ||
                    mem_wdata != '0 || init_done || cmd_ready || rsp_valid)
                    bad++;
            end
            check_int({tag, "_sweep_bad_cycles"}, bad, 0);
            @(negedge clk);
            check_int({tag, "_init_done"}, int'(init_done), 1);
            check_int({tag, "_cmd_ready"}, int'(cmd_ready), 1);
            check_int({tag, "_sweep_stopped"}, int'(mem_wr_valid), 0);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [ADDR_W-1:0] slot,
                          input logic side, input logic [31:0] price, input logic [31:0] qty,
                          input logic [62:0] id, input logic [1:0] exp_st,
                          input logic [DATA_W-1:0] exp_entry, input int exp_wr, input bit hold);
        bit ok;
        int k;
        int wr0;
        int bad;
        exp_t e;
        e.st    = exp_st;
        e.entry = exp_entry;
        exp_q.push_back(e);
        if (hold) rsp_ready = 1'b0;
        wait_ready(ok);
        check_int({tag, "_ready"}, int'(ok), 1);
        if (!ok) begin
            void'(exp_q.pop_back());
            rsp_ready = 1'b1;
            return;
        end
        cmd_op = op; cmd_slot = slot; cmd_side = side;
        cmd_price = price; cmd_qty = qty; cmd_id = id;
        cmd_valid = 1'b1;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                k = i;
                break;
            end
        end
        check_int({tag, "_latency"}, k, (exp_wr != 0) ? 4 : 3);
        if (hold && k != 0) begin
            bad = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (!rsp_valid || cmd_ready || rsp_status != exp_st || rsp_entry != exp_entry)
                    bad++;
            end
            check_int({tag, "_held_bad_cycles"}, bad, 0);
            @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        rsp_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_int({tag, "_rsp_released"}, int'(ok), 1);
        check_int({tag, "_writes"}, wr_cnt - wr0, exp_wr);
    endtask

    task automatic stimulus();
        bit ok;
        bit seen;
        logic [DATA_W-1:0] e1;
        e1 = mk(1'b1, 32'd1000, 32'd100, 63'd7);

        // Reset held for one edge; outputs observed while still in reset.
        @(posedge clk);
        @(negedge clk);
        check_int("reset_outputs",
                  int'({rsp_valid, cmd_ready, mem_wr_valid, mem_rd_valid, init_done}), 0);
        check_ent("reset_rsp_entry", rsp_entry, '0);
        check_ent("reset_mem_wdata", mem_wdata, '0);
        check_int("reset_status_addr", int'({rsp_status, mem_address}), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        init_seq("init");

        do_cmd("add5",      OP_ADD,    10'd5, 1'b1, 32'd1000, 32'd100, 63'd7, ST_OK, e1, 1, 1'b0);
        do_cmd("read5",     OP_READ,   10'd5, 1'b0, 32'd0, 32'd0, 63'd0, ST_OK, e1, 0, 1'b0);
        do_cmd("add5_occ",  OP_ADD,    10'd5, 1'b0, 32'd5, 32'd5, 63'd8, ST_OCCUPIED, e1, 0, 1'b0);
        do_cmd("red30",     OP_REDUCE, 10'd5, 1'b0, 32'd0, 32'd30, 63'd7, ST_OK,
               mk(1'b1, 32'd1000, 32'd70, 63'd7), 1, 1'b0);
        do_cmd("red80",     OP_REDUCE, 10'd5, 1'b0, 32'd0, 32'd80, 63'd7, ST_OK, '0, 1, 1'b0);
        do_cmd("read5_emp", OP_READ,   10'd5, 1'b0, 32'd0, 32'd0, 63'd0, ST_EMPTY, '0, 0, 1'b0);
        do_cmd("readd5",    OP_ADD,    10'd5, 1'b1, 32'd1000, 32'd100, 63'd7, ST_OK, e1, 1, 1'b0);
        do_cmd("cancel_mm", OP_CANCEL, 10'd5, 1'b0, 32'd0, 32'd0, 63'd9, ST_ID_MISMATCH, e1, 0, 1'b1);
        do_cmd("cancel_ok", OP_CANCEL, 10'd5, 1'b0, 32'd0, 32'd0, 63'd7, ST_OK, e1, 1, 1'b0);
        do_cmd("read5_cxl", OP_READ,   10'd5, 1'b0, 32'd0, 32'd0, 63'd0, ST_EMPTY, '0, 0, 1'b0);
        do_cmd("red_empty", OP_REDUCE, 10'd6, 1'b0, 32'd0, 32'd1, 63'd0, ST_EMPTY, '0, 0, 1'b0);
        do_cmd("cxl_empty", OP_CANCEL, 10'd6, 1'b0, 32'd0, 32'd0, 63'd0, ST_EMPTY, '0, 0, 1'b0);
        do_cmd("add1023",   OP_ADD,    10'd1023, 1'b0, 32'd42, 32'd50, 63'd123, ST_OK,
               mk(1'b0, 32'd42, 32'd50, 63'd123), 1, 1'b0);
        do_cmd("red_mm",    OP_REDUCE, 10'd1023, 1'b0, 32'd0, 32'd1, 63'd124, ST_ID_MISMATCH,
               mk(1'b0, 32'd42, 32'd50, 63'd123), 0, 1'b0);
        do_cmd("red49",     OP_REDUCE, 10'd1023, 1'b0, 32'd0, 32'd49, 63'd123, ST_OK,
               mk(1'b0, 32'd42, 32'd1, 63'd123), 1, 1'b0);
        do_cmd("red_exact", OP_REDUCE, 10'd1023, 1'b0, 32'd0, 32'd1, 63'd123, ST_OK, '0, 1, 1'b0);
        do_cmd("read0",     OP_READ,   10'd0, 1'b0, 32'd0, 32'd0, 63'd0, ST_EMPTY, '0, 0, 1'b0);

        // Reset while the ADD write is on the bus: the response must never appear
        // and the clear sweep must restart from slot 0.
        wait_ready(ok);
        check_int("rstwr_ready", int'(ok), 1);
        cmd_op = OP_ADD; cmd_slot = 10'd7; cmd_side = 1'b1;
        cmd_price = 32'd55; cmd_qty = 32'd9; cmd_id = 63'd77;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (mem_wr_valid) seen = 1'b1;
        end
        check_int("rstwr_wr_seen", int'(seen), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_int("rstwr_after_reset",
                  int'({rsp_valid, init_done, cmd_ready, mem_wr_valid}), 0);
        init_seq("reinit");
        do_cmd("read7",     OP_READ,   10'd7, 1'b0, 32'd0, 32'd0, 63'd0, ST_EMPTY, '0, 0, 1'b0);

        repeat (3) @(negedge clk);
        check_int("scoreboard_drained", exp_q.size(), 0);
        check_int("strobe_overlap", overlap, 0);
    endtask

    initial begin
        fork
            monitor_loop();
            stimulus();
            begin
                #2000000;
                $display("FAIL watchdog: simulation exceeded time limit");
                $fatal(1, "watchdog");
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
